// File: rtl/rjc_pkg.sv
// Shared constants and helpers for the ring/Johnson shift counter.
package rjc_pkg;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;
  localparam logic DIR_UP       = 1'b0;
  localparam logic DIR_DN       = 1'b1;

  function automatic logic [31:0] home_state(
    input logic        mode,
    input int unsigned n
  );
    home_state = (mode == MODE_RING && n != 0) ? 32'd1 : 32'd0;
  endfunction

endpackage

// File: rtl/rjc_legal_check.sv
// Legality checker for ring (one-hot) and Johnson (anchored run) states.
// Only built when RJC_SELF_CORRECT_EN is defined.
`ifdef RJC_SELF_CORRECT_EN
module rjc_legal_check
  import rjc_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] value,
  input  logic         mode,
  output logic         legal
);

  logic [N-1:0] inv;
  logic         lsb_run;
  logic         msb_run;
  logic         one_hot;

  assign inv = ~value;
  // x & (x+1) is zero only for a run of ones starting at bit 0
  assign lsb_run = ((value & (value + N'(1))) == '0);
  assign msb_run = ((inv & (inv + N'(1))) == '0);
  assign one_hot = $onehot(value);

  assign legal = (mode == MODE_JOHNSON) ? (lsb_run | msb_run) : one_hot;

endmodule
`endif

// File: rtl/ring_johnson_counter.sv
// N-bit ring / Johnson sequencer with load, direction, wrap pulse.
// Optional illegal-state correction: define RJC_SELF_CORRECT_EN.
module ring_johnson_counter
  import rjc_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         dir,
  input  logic         mode,
  input  logic         load,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] q,
  output logic         wrap,
  output logic         err
);

  logic         mode_q, mode_d;
  logic [N-1:0] q_q, q_d;
  logic         wrap_q, wrap_d;
  logic [N-1:0] step;
  logic [N-1:0] home_new;
  logic [N-1:0] home_cur;

  assign home_new = N'(home_state(mode, N));
  assign home_cur = N'(home_state(mode_q, N));

  always_comb begin
    step = q_q;
    unique case ({mode_q, dir})
      {MODE_RING, DIR_UP}:    step = {q_q[N-2:0], q_q[N-1]};
      {MODE_RING, DIR_DN}:    step = {q_q[0], q_q[N-1:1]};
      {MODE_JOHNSON, DIR_UP}: step = {q_q[N-2:0], ~q_q[N-1]};
      {MODE_JOHNSON, DIR_DN}: step = {~q_q[0], q_q[N-1:1]};
      default:                step = q_q;
    endcase
  end

`ifdef RJC_SELF_CORRECT_EN
  logic err_q, err_d;
  logic ld_legal;
  logic q_legal;

  rjc_legal_check #(.N(N)) u_chk_ld (
    .value (load_val),
    .mode  (mode_q),
    .legal (ld_legal)
  );

  rjc_legal_check #(.N(N)) u_chk_q (
    .value (q_q),
    .mode  (mode_q),
    .legal (q_legal)
  );

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    mode_d = mode_q;
    q_d    = q_q;
    wrap_d = 1'b0;
`ifdef RJC_SELF_CORRECT_EN
    err_d  = 1'b0;
`endif
    if (reset || mode != mode_q) begin
      mode_d = mode;
      q_d    = home_new;
    end else if (load) begin
`ifdef RJC_SELF_CORRECT_EN
      if (ld_legal) begin
        q_d = load_val;
      end else begin
        q_d   = home_cur;
        err_d = 1'b1;
      end
`else
      q_d = load_val;
`endif
    end else if (en) begin
`ifdef RJC_SELF_CORRECT_EN
      if (!q_legal) begin
        q_d   = home_cur;
        err_d = 1'b1;
      end else begin
        q_d    = step;
        wrap_d = (step == home_cur);
      end
`else
      q_d    = step;
      wrap_d = (step == home_cur);
`endif
    end
  end

  always_ff @(posedge clk) begin
    mode_q <= mode_d;
    q_q    <= q_d;
    wrap_q <= wrap_d;
`ifdef RJC_SELF_CORRECT_EN
    err_q  <= err_d;
`endif
  end

  assign q    = q_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_ring_johnson_counter.sv
// Self-checking bench: reference model plus directed literal checks.
module tb_ring_johnson_counter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         en = 1'b0;
  logic         dir = 1'b0;
  logic         mode = 1'b0;
  logic         load = 1'b0;
  logic [N-1:0] load_val = '0;
  logic [N-1:0] q;
  logic         wrap;
  logic         err;

  int n_chk = 0;
  int n_fail = 0;

  ring_johnson_counter #(.N(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .dir      (dir),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .wrap     (wrap),
    .err      (err)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] m_home(input bit md);
    return md ? N'(0) : N'(1);
  endfunction

  // Arithmetic view: doubling/halving with a wrapped-in top or bottom bit
  function automatic logic [N-1:0] m_step(input logic [N-1:0] v,
                                          input bit md, input bit dn);
    int x, top, full, b;
    x = int'(v);
    top = 1 << (N - 1);
    full = 1 << N;
    if (!dn) begin
      b = x / top;
      if (md) b = 1 - b;
      return N'((x * 2) % full + b);
    end
    b = x % 2;
    if (md) b = 1 - b;
    return N'(x / 2 + b * top);
  endfunction

`ifdef RJC_SELF_CORRECT_EN
  function automatic bit m_legal(input logic [N-1:0] v, input bit md);
    int ones;
    int x;
    x = int'(v);
    if (!md) begin
      ones = 0;
      for (int i = 0; i < N; i++) ones += (x >> i) & 1;
      return ones == 1;
    end
    for (int k = 0; k <= N; k++)
      if (x == (1 << k) - 1 || x == (1 << N) - (1 << k)) return 1;
    return 0;
  endfunction
`endif

  bit           m_ok = 0;
  bit           m_mode;
  logic [N-1:0] m_q;
  bit           m_w;
  bit           m_e;

  always @(posedge clk) begin
    m_w <= 0;
    m_e <= 0;
    if (reset) begin
      m_ok   <= 1;
      m_mode <= mode;
      m_q    <= m_home(mode);
    end else if (mode != m_mode) begin
      m_mode <= mode;
      m_q    <= m_home(mode);
    end else if (load) begin
`ifdef RJC_SELF_CORRECT_EN
      if (m_legal(load_val, m_mode)) m_q <= load_val;
      else begin
        m_q <= m_home(m_mode);
        m_e <= 1;
      end
`else
      m_q <= load_val;
`endif
    end else if (en) begin
`ifdef RJC_SELF_CORRECT_EN
      if (!m_legal(m_q, m_mode)) begin
        m_q <= m_home(m_mode);
        m_e <= 1;
      end else begin
        m_q <= m_step(m_q, m_mode, dir);
        m_w <= (m_step(m_q, m_mode, dir) == m_home(m_mode));
      end
`else
      m_q <= m_step(m_q, m_mode, dir);
      m_w <= (m_step(m_q, m_mode, dir) == m_home(m_mode));
`endif
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      n_chk++;
      if (q !== m_q || wrap !== m_w || err !== m_e) begin
        n_fail++;
        $display("FAIL model t=%0t q=%b wrap=%b err=%b want q=%b wrap=%b err=%b",
                 $time, q, wrap, err, m_q, m_w, m_e);
      end
    end
  end

  task automatic tick(input string nm, input logic [N-1:0] eq,
                      input bit ew, input bit ee);
    @(posedge clk);
    #1;
    n_chk++;
    if (q !== eq || wrap !== ew || err !== ee) begin
      n_fail++;
      $display("FAIL %s q=%b wrap=%b err=%b want q=%b wrap=%b err=%b",
               nm, q, wrap, err, eq, ew, ee);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1; mode = 0; en = 1; dir = 0;
    tick("reset_ring", 4'b0001, 0, 0);
    reset = 0;
    tick("ring_up1", 4'b0010, 0, 0);
    tick("ring_up2", 4'b0100, 0, 0);
    tick("ring_up3", 4'b1000, 0, 0);
    tick("ring_wrap", 4'b0001, 1, 0);
    tick("ring_up5", 4'b0010, 0, 0);
    tick("ring_up6", 4'b0100, 0, 0);
    dir = 1;
    tick("ring_dn1", 4'b0010, 0, 0);
    tick("ring_dn_wrap", 4'b0001, 1, 0);
    en = 0;
    tick("ring_hold1", 4'b0001, 0, 0);
    tick("ring_hold2", 4'b0001, 0, 0);

    load = 1; load_val = 4'b0110;
`ifdef RJC_SELF_CORRECT_EN
    tick("ring_bad_load", 4'b0001, 0, 1);
    load = 0; en = 1; dir = 0;
    tick("ring_after_fix", 4'b0010, 0, 0);
`else
    tick("ring_bad_load", 4'b0110, 0, 0);
    load = 0; en = 1; dir = 0;
    tick("ring_bad_step", 4'b1100, 0, 0);
`endif

    reset = 1; mode = 1;
    tick("reset_john", 4'b0000, 0, 0);
    reset = 0;
    tick("john1", 4'b0001, 0, 0);
    tick("john2", 4'b0011, 0, 0);
    tick("john3", 4'b0111, 0, 0);
    tick("john4", 4'b1111, 0, 0);
    tick("john5", 4'b1110, 0, 0);
    tick("john6", 4'b1100, 0, 0);
    tick("john7", 4'b1000, 0, 0);
    tick("john_wrap", 4'b0000, 1, 0);
    run(3);
    mode = 0; load = 1; load_val = 4'b1000;
    tick("mode_change", 4'b0001, 0, 0);
    load = 0;
    tick("ring_after_mc", 4'b0010, 0, 0);

    reset = 1; mode = 1; load = 1; load_val = 4'b1000;
    tick("reset_over_load", 4'b0000, 0, 0);
    reset = 0; load = 0; dir = 1;
    tick("john_dn1", 4'b1000, 0, 0);
    tick("john_dn2", 4'b1100, 0, 0);
    run(6);
    dir = 0; load = 1; load_val = 4'b0101;
`ifdef RJC_SELF_CORRECT_EN
    tick("john_bad_load", 4'b0000, 0, 1);
`else
    tick("john_bad_load", 4'b0101, 0, 0);
    load = 0;
    tick("john_bad_step", 4'b1011, 0, 0);
`endif
    load = 0;

    for (int i = 0; i < 48; i++) begin
      en = (i % 5) != 4;
      dir = ((i / 6) % 2) == 1;
      mode = ((i / 16) % 2) == 1;
      load = (i % 11) == 10;
      load_val = N'(i * 7);
      @(posedge clk);
      #1;
    end
    load = 0;
    run(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
